// File: rtl/bsg_counter_set_step_en_if.sv
// Control and status bundle for bsg_counter_set_step_en: load/step inputs in, count and flags out.
// master drives set/val/up/down; slave (the counter) drives count and status.
interface bsg_counter_set_step_en_if #(
    parameter int width_p  = 10,
    parameter int step_w_p = 1
);
    logic                set_i;
    logic [width_p-1:0]  val_i;
    logic [step_w_p-1:0] up_i;
    logic [step_w_p-1:0] down_i;
    logic [width_p-1:0]  count_o;
    logic                at_max_o;
    logic                at_zero_o;
    logic                ovf_o;
    logic                unf_o;

    modport master (
        output set_i, val_i, up_i, down_i,
        input  count_o, at_max_o, at_zero_o, ovf_o, unf_o
    );

    modport slave (
        input  set_i, val_i, up_i, down_i,
        output count_o, at_max_o, at_zero_o, ovf_o, unf_o
    );
endinterface

// File: rtl/bsg_counter_set_step_en.sv
// Up/down step counter in [0, max_val_p] with load, saturate or wrap, and over/underflow flags.
// Latency: one cycle to count/flags; no backpressure. BSG_COUNTER_SET_STEP_STICKY_EN makes ovf/unf sticky.
// Interface widths must match width_lp/step_w_lp derived here.
module bsg_counter_set_step_en #(
    parameter int max_val_p   = 1000,
    parameter int max_step_p  = 1,
    parameter int wrap_p      = 0,
    parameter int reset_val_p = 0,
    localparam int width_lp   = (max_val_p + 1 > 1) ? $clog2(max_val_p + 1) : 1,
    localparam int step_w_lp  = (max_step_p + 1 > 1) ? $clog2(max_step_p + 1) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bsg_counter_set_step_en_if.slave    ctr
);
    localparam int raw_w_lp = width_lp + 2;

    if (max_step_p < 1 || max_step_p > max_val_p) begin : g_bad_step
        $error("bsg_counter_set_step_en: max_step_p must be in [1, max_val_p]");
    end
    if (reset_val_p < 0 || reset_val_p > max_val_p) begin : g_bad_reset
        $error("bsg_counter_set_step_en: reset_val_p must be in [0, max_val_p]");
    end

    localparam logic [width_lp-1:0]        max_lp   = width_lp'(max_val_p);
    localparam logic [width_lp-1:0]        reset_lp = width_lp'(reset_val_p);
    localparam logic signed [raw_w_lp-1:0] max_s    = raw_w_lp'(max_val_p);
    localparam logic signed [raw_w_lp-1:0] mod_s    = raw_w_lp'(max_val_p + 1);

    logic [width_lp-1:0]        count_q, count_d;
    logic                       ovf_q, ovf_d;
    logic                       unf_q, unf_d;
    logic signed [raw_w_lp-1:0] up_s, down_s, cur_s, raw_s;
    logic                       raw_hi, raw_lo;

    // Widen before the add so neither carry nor borrow is lost.
    assign up_s   = signed'({{(raw_w_lp - step_w_lp){1'b0}}, ctr.up_i});
    assign down_s = signed'({{(raw_w_lp - step_w_lp){1'b0}}, ctr.down_i});
    assign cur_s  = signed'({2'b00, count_q});
    assign raw_s  = cur_s + up_s - down_s;
    assign raw_hi = (raw_s > max_s);
    assign raw_lo = (raw_s < 0);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (ctr.set_i) begin
            count_d = (ctr.val_i > max_lp) ? max_lp : ctr.val_i;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (raw_hi) begin
                count_d = (wrap_p != 0) ? width_lp'(raw_s - mod_s) : max_lp;
            end else if (raw_lo) begin
                count_d = (wrap_p != 0) ? width_lp'(raw_s + mod_s) : '0;
            end else begin
                count_d = width_lp'(raw_s);
            end
`ifdef BSG_COUNTER_SET_STEP_STICKY_EN
            ovf_d = ovf_q | raw_hi;
            unf_d = unf_q | raw_lo;
`else
            ovf_d = raw_hi;
            unf_d = raw_lo;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= reset_lp;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ctr.count_o   = count_q;
    assign ctr.at_max_o  = (count_q == max_lp);
    assign ctr.at_zero_o = (count_q == '0);
    assign ctr.ovf_o     = ovf_q;
    assign ctr.unf_o     = unf_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (ctr.up_i <= step_w_lp'(max_step_p) && ctr.down_i <= step_w_lp'(max_step_p))
                else $error("bsg_counter_set_step_en: step exceeds max_step_p");
        end
    end
`endif
endmodule
